seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for a common-anode 7-segment bank. Holds a
//   per-digit code buffer written by the note/score logic, cycles one active-low

---
 rtl/seg_scan_ctrl_if.sv | 26 ++
 rtl/seg_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle of seg_scan_ctrl: buffer write port, scan enable, dp mask and pin outputs.
// Master is the note/score logic side; slave is the scan controller.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 8,
  parameter int IDX_W      = 3
);
  logic                  enable;
  logic                  wr_vld;
  logic [IDX_W-1:0]      wr_addr;
  logic [3:0]            wr_dat;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame;

  modport master (
    output enable, wr_vld, wr_addr, wr_dat, dp_mask,
    input  an, seg, dp, frame
  );

  modport slave (
    input  enable, wr_vld, wr_addr, wr_dat, dp_mask,
    output an, seg, dp, frame
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed common-anode 7-seg scanner with a dead-time window per digit slot.
// Outputs registered in step with the FSM; writes accepted every cycle, no backpressure.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int IDX_W      = 3,
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_scan_if.slave  bus
);
  localparam int                CNT_W     = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W:0]    NUM_IDX   = (IDX_W + 1)'(NUM_DIGITS);
  localparam logic [CNT_W-1:0]  DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, DEAD, ON} state_t;

  state_t                state_q, state_nxt;
  logic [IDX_W-1:0]      idx_q, idx_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic [3:0]            digit_buf [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic                  frame_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      4'd10:   seg_decode = 7'h77;
      4'd11:   seg_decode = 7'h3F;
      4'd12:   seg_decode = 7'h7E;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    cnt_nxt   = cnt_q;
    frame_nxt = 1'b0;
    if (!bus.enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_nxt = DEAD;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
        DEAD: begin
          cnt_nxt = cnt_q + 1'b1;
          if (cnt_q == DEAD_LAST) state_nxt = ON;
        end
        ON: begin
          if (cnt_q == DIV_LAST) begin
            cnt_nxt   = '0;
            state_nxt = DEAD;
            idx_nxt   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            frame_nxt = (idx_q == LAST_IDX);
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are derived from the next state so pins and FSM change on the same edge;
  // segment data is read from the pre-write buffer, so a write shows one cycle later.
  always_comb begin
    an_nxt  = '1;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (state_nxt != IDLE) begin
      seg_nxt = seg_decode(digit_buf[idx_nxt]);
      dp_nxt  = ~bus.dp_mask[idx_nxt];
    end
    if (state_nxt == ON) an_nxt[idx_nxt] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      bus.an    <= '1;
      bus.seg   <= 7'h7F;
      bus.dp    <= 1'b1;
      bus.frame <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_buf[i] <= 4'hF;
    end else begin
      state_q   <= state_nxt;
      idx_q     <= idx_nxt;
      cnt_q     <= cnt_nxt;
      bus.an    <= an_nxt;
      bus.seg   <= seg_nxt;
      bus.dp    <= dp_nxt;
      bus.frame <= frame_nxt;
      if (bus.wr_vld && ({1'b0, bus.wr_addr} < NUM_IDX))
        digit_buf[bus.wr_addr] <= bus.wr_dat;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a 4-digit, 8-cycle-slot, 2-cycle-dead configuration.
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seg_scan_if #(.NUM_DIGITS(4), .IDX_W(2)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS(4), .IDX_W(2), .SCAN_DIV(8), .DEAD_CYC(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"},  32'(bus.an),  32'hF);
    check({tag, "_seg"}, 32'(bus.seg), 32'h7F);
    check({tag, "_dp"},  32'(bus.dp),  32'h1);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [3:0] dat);
    bus.wr_vld  = 1'b1;
    bus.wr_addr = addr;
    bus.wr_dat  = dat;
    tick();
    bus.wr_vld  = 1'b0;
  endtask

  // One full slot: 2 dead cycles, 6 cycles with exp_an; frame only on the first cycle.
  task automatic check_slot(input string tag, input logic [3:0] exp_an,
                            input logic [6:0] exp_seg, input logic exp_dp,
                            input logic exp_frame);
    for (int i = 0; i < 8; i++) begin
      tick();
      check({tag, "_an"},    32'(bus.an),    (i < 2) ? 32'hF : 32'(exp_an));
      check({tag, "_seg"},   32'(bus.seg),   32'(exp_seg));
      check({tag, "_dp"},    32'(bus.dp),    32'(exp_dp));
      check({tag, "_frame"}, 32'(bus.frame), (i == 0) ? 32'(exp_frame) : 32'h0);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.enable  = 1'b0;
    bus.wr_vld  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_dat  = '0;
    bus.dp_mask = '0;

    // Reset state, then released with scanning disabled
    repeat (2) tick();
    check_dark("rst");
    check("rst_frame", 32'(bus.frame), 32'h0);
    rst_n = 1'b1;
    wr(2'd0, 4'd1);
    wr(2'd1, 4'd2);
    wr(2'd2, 4'd3);
    wr(2'd3, 4'd4);
    repeat (3) tick();
    check_dark("idle");

    // Scan of 1,2,3,4, then frame pulse entering the next frame
    bus.enable = 1'b1;
    check_slot("s2_d0", 4'hE, 7'h79, 1'b1, 1'b0);
    check_slot("s2_d1", 4'hD, 7'h24, 1'b1, 1'b0);
    check_slot("s2_d2", 4'hB, 7'h30, 1'b1, 1'b0);
    check_slot("s2_d3", 4'h7, 7'h19, 1'b1, 1'b0);
    check_slot("s2_d0b", 4'hE, 7'h79, 1'b1, 1'b1);

    // Bars, blank and decimal points
    bus.enable = 1'b0;
    tick();
    check_dark("s3_off");
    wr(2'd0, 4'd10);
    wr(2'd1, 4'd11);
    wr(2'd2, 4'd12);
    wr(2'd3, 4'd15);
    bus.dp_mask = 4'b0101;
    check_dark("s3_wr");
    bus.enable = 1'b1;
    check_slot("s3_d0", 4'hE, 7'h77, 1'b0, 1'b0);
    check_slot("s3_d1", 4'hD, 7'h3F, 1'b1, 1'b0);
    check_slot("s3_d2", 4'hB, 7'h7E, 1'b0, 1'b0);
    check_slot("s3_d3", 4'h7, 7'h7F, 1'b1, 1'b0);

    // Write to the active digit mid-ON
    tick();
    check("s4_frame", 32'(bus.frame), 32'h1);
    repeat (2) tick();
    check("s4_on_an", 32'(bus.an), 32'hE);
    wr(2'd0, 4'd8);
    check("s4_same_seg", 32'(bus.seg), 32'h77);
    tick();
    check("s4_new_seg", 32'(bus.seg), 32'h00);
    check("s4_new_an",  32'(bus.an),  32'hE);
    // Write to another digit while digit 1 shows
    repeat (6) tick();
    check("s4_d1_an", 32'(bus.an), 32'hD);
    wr(2'd3, 4'd8);
    tick();
    check("s4_d1_seg", 32'(bus.seg), 32'h3F);
    check("s4_d1_an2", 32'(bus.an),  32'hD);

    // Drop enable in digit 2 ON, raise it 5 cycles later
    repeat (6) tick();
    check("s5_d2_an", 32'(bus.an), 32'hB);
    bus.enable = 1'b0;
    tick();
    check_dark("s5_drop");
    repeat (4) tick();
    check_dark("s5_low");
    bus.enable = 1'b1;
    check_slot("s5_d0", 4'hE, 7'h00, 1'b0, 1'b0);

    // Asynchronous reset mid-ON
    bus.dp_mask = 4'b0000;
    repeat (3) tick();
    check("s6_on_an", 32'(bus.an), 32'hD);
    #2;
    rst_n = 1'b0;
    #1;
    check_dark("s6_async");
    check("s6_frame", 32'(bus.frame), 32'h0);
    tick();
    check_dark("s6_held");
    rst_n = 1'b1;
    check_slot("s6_d0", 4'hE, 7'h7F, 1'b1, 1'b0);
    check_slot("s6_d1", 4'hD, 7'h7F, 1'b1, 1'b0);
    check_slot("s6_d2", 4'hB, 7'h7F, 1'b1, 1'b0);
    check_slot("s6_d3", 4'h7, 7'h7F, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
